gcd_responder: RTL

Callee-side implementation of the method-call handshake (`*_req` in, `*_busy` / `*_return` out) that the simulation benches drive against generated method modules. It computes the greatest common divisor of two unsigned operands by iterative subtraction, taking one subtraction per clock. It is the responder a bench or a calling FSM invokes, and it serves as a reference callee for handshake conformance tests.

---
 rtl/gcd_responder.sv | 90 +++++++++
 1 files changed

// File: rtl/gcd_responder.sv
// gcd_responder: method-call callee computing gcd(a, b) by repeated subtraction,
// one subtraction per clock, with a registered busy/return handshake.
module gcd_responder #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] gcd_a,
    input  logic [WIDTH-1:0] gcd_b,
    input  logic             gcd_req,
    output logic             gcd_busy,
    output logic [WIDTH-1:0] gcd_return
);

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;

    state_t           w_state_nxt;
    logic [WIDTH-1:0] w_a_nxt;
    logic [WIDTH-1:0] w_b_nxt;
    logic             w_busy_nxt;
    logic [WIDTH-1:0] w_ret_nxt;

    // State, working operands and handshake outputs; reset abandons any call
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_a        <= '0;
            r_b        <= '0;
            gcd_busy   <= 1'b0;
            gcd_return <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_a        <= w_a_nxt;
            r_b        <= w_b_nxt;
            gcd_busy   <= w_busy_nxt;
            gcd_return <= w_ret_nxt;
        end
    end

    // Next-state: accept in IDLE, then finish on a zero/equal operand or subtract
    always_comb begin
        w_state_nxt = r_state;
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        w_busy_nxt  = gcd_busy;
        w_ret_nxt   = gcd_return;
        case (r_state)
            IDLE: begin
                if (gcd_req) begin
                    w_a_nxt     = gcd_a;
                    w_b_nxt     = gcd_b;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = CALC;
                end
            end
            CALC: begin
                if (r_a == '0) begin
                    w_ret_nxt   = r_b;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = IDLE;
                end else if (r_b == '0) begin
                    w_ret_nxt   = r_a;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = IDLE;
                end else if (r_a == r_b) begin
                    w_ret_nxt   = r_a;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = IDLE;
                end else if (r_a > r_b) begin
                    // larger operand is always the minuend, so no underflow
                    w_a_nxt = WIDTH'(r_a - r_b);
                end else begin
                    w_b_nxt = WIDTH'(r_b - r_a);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

endmodule
